// File: rtl/uart_tx_fifo_drain_if.sv
// Handshake bundle between the FIFO read port, tx control and the TX pin.
// The master side drives tx_en and the FIFO flags; the slave side is the UART.
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rd;
  logic                  tx;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output tx_en,
    output fifo_empty,
    output fifo_rdata,
    input  fifo_rd,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_en,
    input  fifo_empty,
    input  fifo_rdata,
    output fifo_rd,
    output tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// 8N1 UART transmitter that pops bytes from a FIFO read port
// and sends them back-to-back while tx_en is high.
module uart_tx_fifo_drain #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_fifo_drain_if.slave  bus
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic                  tx_q;
  logic                  done_q;
  logic                  bit_end;

  assign shift_d = shift_q >> 1;
  assign bit_end = (cnt_q == CNT_MAX);

  // Combinational pop so rdata is captured on the edge the pointer moves.
  assign bus.fifo_rd = (state_q == IDLE) & bus.tx_en
                     & ~bus.fifo_empty & ~rst;

  assign bus.tx      = tx_q;
  assign bus.tx_done = done_q;
  assign bus.tx_busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (bus.fifo_rd) begin
            shift_q <= bus.fifo_rdata;
            tx_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == IDX_MAX) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= shift_d;
              tx_q    <= shift_d[0];
              idx_q   <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: FIFO model, per-cycle line checker
// and a queue of expected bytes filled as bytes are written.
module tb_uart_tx_fifo_drain;

  localparam int BC = 10;
  localparam int FL = 10 * BC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_fifo_drain #(
    .CLK_FREQ  (100),
    .BAUD      (10),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [32];
  int rp = 0;
  int wp = 0;
  int cyc = 0;
  int pops = 0;
  int pop_t [$];
  logic [7:0] exp_q [$];
  int frames = 0;

  assign bus.fifo_empty = (rp == wp);
  assign bus.fifo_rdata = mem[rp[4:0]];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [7:0] b);
    mem[wp[4:0]] = b;
    wp = wp + 1;
    exp_q.push_back(b);
  endtask

  task automatic wait_frames(int target, int maxc);
    int n = 0;
    while (frames < target && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("frames_reached", 32'(frames >= target), 1);
  endtask

  // FIFO read side: pop on any edge where the DUT strobes fifo_rd.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd === 1'b1) begin
      chk("pop_nonempty", 32'(rp != wp), 1);
      rp   <= rp + 1;
      pops <= pops + 1;
      pop_t.push_back(cyc);
    end
  end

  // Line checker: each frame is compared level by level against
  // the next expected byte, plus the tx_done pulse at its end.
  initial begin
    int k;
    logic busy_m;
    logic [9:0] fr;
    k = 0;
    busy_m = 1'b0;
    fr = '1;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_m = 1'b0;
        k = 0;
      end else if (!busy_m) begin
        chk("idle_done_low", bus.tx_done, 0);
        if (bus.tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 0, 1);
            fr = 10'h3fe;
          end else begin
            fr = {1'b1, exp_q.pop_front(), 1'b0};
          end
          busy_m = 1'b1;
          k = 0;
        end
      end else begin
        k++;
        if (k < FL) begin
          chk("tx_level", bus.tx, fr[k/BC]);
          chk("done_low", bus.tx_done, 0);
          chk("busy_high", bus.tx_busy, 1);
        end else begin
          chk("tx_done_pulse", bus.tx_done, 1);
          chk("tx_idle_after", bus.tx, 1);
          frames++;
          busy_m = 1'b0;
        end
      end
    end
  end

  initial begin
    int p;
    int f;
    bus.tx_en = 1'b0;

    // reset and idle with empty FIFO
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.tx_busy, 0);
    chk("rst_done", bus.tx_done, 0);
    chk("rst_rd", bus.fifo_rd, 0);
    rst = 1'b0;
    bus.tx_en = 1'b1;
    repeat (1000) @(negedge clk);
    chk("idle_nopop", pops, 0);
    chk("idle_tx", bus.tx, 1);
    chk("idle_busy", bus.tx_busy, 0);

    // single byte
    push(8'hA5);
    wait_frames(1, 300);
    chk("single_pops", pops, 1);

    // burst of three
    repeat (3) @(negedge clk);
    p = pop_t.size();
    push(8'h55);
    push(8'h0F);
    push(8'hFF);
    wait_frames(4, 600);
    chk("burst_pops", pops, 4);
    chk("burst_gap1", pop_t[p+1] - pop_t[p], 101);
    chk("burst_gap2", pop_t[p+2] - pop_t[p+1], 101);
    repeat (5) @(negedge clk);
    chk("burst_empty", bus.fifo_empty, 1);
    chk("burst_tx_idle", bus.tx, 1);

    // flow control
    bus.tx_en = 1'b0;
    push(8'h12);
    push(8'h34);
    repeat (20) @(negedge clk);
    p = pops;
    chk("fc_nopop", p, 4);
    chk("fc_tx_high", bus.tx, 1);
    bus.tx_en = 1'b1;
    @(negedge clk);
    chk("fc_pop_next", pops, p + 1);
    repeat (30) @(negedge clk);
    bus.tx_en = 1'b0;
    f = frames;
    wait_frames(f + 1, 200);
    repeat (150) @(negedge clk);
    chk("fc_no_more", pops, p + 1);
    chk("fc_tx_idle", bus.tx, 1);
    chk("fc_left", bus.fifo_empty, 0);
    bus.tx_en = 1'b1;
    wait_frames(f + 2, 300);
    chk("fc_drained", exp_q.size(), 0);

    // reset in the middle of data bit 3
    bus.tx_en = 1'b0;
    push(8'h3C);
    push(8'h81);
    repeat (2) @(negedge clk);
    p = pops;
    bus.tx_en = 1'b1;
    @(negedge clk);
    chk("mr_pop", pops, p + 1);
    repeat (43) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_tx_high", bus.tx, 1);
    chk("mr_busy_low", bus.tx_busy, 0);
    chk("mr_rd_low", bus.fifo_rd, 0);
    repeat (3) @(negedge clk);
    chk("mr_hold_pops", pops, p + 1);
    rst = 1'b0;
    f = frames;
    @(negedge clk);
    chk("mr_repop", pops, p + 2);
    wait_frames(f + 1, 300);
    chk("mr_exp_empty", exp_q.size(), 0);

    // fill sixteen then drain
    bus.tx_en = 1'b0;
    repeat (2) @(negedge clk);
    p = pops;
    f = frames;
    for (int i = 0; i < 16; i++) push(8'(i));
    repeat (5) @(negedge clk);
    chk("full_nopop", pops, p);
    bus.tx_en = 1'b1;
    wait_frames(f + 16, 16 * 101 + 100);
    chk("full_pops", pops, p + 16);
    chk("full_exp_empty", exp_q.size(), 0);
    chk("full_fifo_empty", bus.fifo_empty, 1);
    repeat (20) @(negedge clk);
    chk("full_tx_idle", bus.tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- UART transmitter that drains bytes from the read side of the 16-entry `fifo` and serializes them on the TX line as 8N1 frames.
- Sits between the `fifo` read port (`rd`/`rdata`/`empty`) and the board TX pin, opposite the RX path that fills the FIFO.
- Pops one byte per frame and transmits frames back-to-back while the FIFO is non-empty and `tx_en` is high.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- DATA_WIDTH, 8: frame data bits; must match the FIFO `DATA_WIDTH`.
- BIT_CYCLES is derived as CLK_FREQ/BAUD (integer division). It must be >= 2. The counter width is $clog2(BIT_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- tx_en  in  1  permits starting a new frame; a frame in progress always completes.
- fifo_empty  in  1  FIFO `empty` flag.
- fifo_rdata  in  DATA_WIDTH  FIFO `rdata`; combinational from the read pointer.
- fifo_rd  out  1  FIFO read strobe; one-cycle pulse per popped byte.
- tx  out  1  serial line, idle high; registered.
- tx_busy  out  1  high whenever state != IDLE.
- tx_done  out  1  one-cycle pulse at frame end; registered.

Behaviour:
- Reset (async) values:
  - state=IDLE, tx=1, tx_done=0, tx_busy=0.
  - Baud counter=0, bit index=0, shift register=0.
  - fifo_rd is forced 0 while rst=1.
- States: IDLE, START, DATA, STOP.
- fifo_rd = (state==IDLE) & tx_en & ~fifo_empty & ~rst. This is combinational so that `rdata` is captured in the same cycle the FIFO pointer advances.
- IDLE:
  - tx=1.
  - On an edge where fifo_rd=1: load the shift register with fifo_rdata, tx<=0, clear the baud counter, and go to START.
  - Exactly one fifo_rd pulse occurs per frame. No pop is ever attempted while fifo_empty=1.
- START:
  - tx held 0 for BIT_CYCLES clocks.
  - When the counter reaches BIT_CYCLES-1: counter<=0, bit index<=0, tx<=shift[0], go to DATA.
- DATA:
  - Each bit is held BIT_CYCLES clocks, LSB first.
  - At each bit end: shift right and tx<=next bit.
  - After bit DATA_WIDTH-1 ends: tx<=1, go to STOP.
- STOP:
  - tx=1 for BIT_CYCLES clocks.
  - At the end: tx_done<=1 for one cycle and go to IDLE.
- Frame timing:
  - tx falls on the same edge that samples fifo_rd.
  - Frame length on the line is (DATA_WIDTH+2)*BIT_CYCLES clocks.
  - Back-to-back frames are separated by exactly one IDLE clock of tx=1.
- tx_en:
  - Sampled only in IDLE.
  - Deasserting it mid-frame does not abort the frame.
  - When tx_en is low, the FIFO is untouched.
- The fifo_rdata value seen after the pop edge is ignored; only the latched shift register drives tx.
- Reset mid-frame:
  - tx returns to 1 immediately.
  - The byte already popped is discarded, not re-sent.
  - After reset release, a new pop happens on the first clock with tx_en & ~fifo_empty.
- FIFO full or simultaneous FIFO write: no special case. The block depends only on fifo_empty. The FIFO accepts wr&rd in the same cycle, and the popped byte is the one at raddr.
- Counter arithmetic: unsigned, compared against BIT_CYCLES-1, never wraps past it.

Test Plan:
- Reset/idle: rst pulse with fifo_empty=1 -> tx=1, tx_busy=0, fifo_rd never asserts over 1000 clocks.
- Single byte (CLK_FREQ=100, BAUD=10, so BIT_CYCLES=10): FIFO holds 0xA5, tx_en=1 ->
  - one fifo_rd pulse.
  - tx sequence 0, 1,0,1,0,0,1,0,1, 1, each level lasting 10 clocks.
  - tx_done pulses once, 100 clocks after tx falls.
- Burst: 0x55, 0x0F, 0xFF written into the FIFO ->
  - three fifo_rd pulses spaced 101 clocks apart.
  - Decoded bytes arrive in order.
  - fifo_empty=1 after the third pop, then tx idles high.
- Flow control: tx_en=0 with 2 bytes queued -> no pop and tx=1. Raise tx_en -> a pop occurs on the next clock. Drop tx_en mid-frame -> that frame completes and no further pop occurs.
- Reset mid-frame: assert rst during DATA bit 3 of 0x3C ->
  - tx=1 within the same cycle.
  - The byte is not retransmitted.
  - The next queued byte 0x81 transmits correctly after release.
- FIFO full: fill 16 bytes 0x00..0x0F while tx_en=0, then enable -> 16 frames carrying 0x00..0x0F in order, no duplicates or drops.
